ejtag_dreg_arb: RTL and testbench

//  Arbitrates and sequences register accesses to the EJTAG data-breakpoint unit between two requesters: the

---
 rtl/ejtag_dreg_arb.sv | 152 +++++++++++++++
 tb/tb_ejtag_dreg_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ejtag_dreg_arb.sv
// Two-requester (probe / debug software) sequencer for the EJTAG data-breakpoint register bus.
// Latency: grant edge N -> ACK in cycle N+3 (reject path N+1); one access per 4 cycles; REQ sampled only in IDLE.
module ejtag_dreg_arb #(
    parameter int NDBRK = 2
) (
    input  logic        CORE_CLOCK,
    input  logic        RESET_D1_R_N,
    input  logic        PRB_REQ,
    input  logic        PRB_RW,
    input  logic        PRB_SEL,
    input  logic [5:0]  PRB_ADDR,
    input  logic [31:0] PRB_WDATA,
    output logic        PRB_ACK,
    output logic        PRB_ERR,
    output logic [31:0] PRB_RDATA,
    input  logic        SW_REQ,
    input  logic        SW_RW,
    input  logic        SW_SEL,
    input  logic [5:0]  SW_ADDR,
    input  logic [31:0] SW_WDATA,
    output logic        SW_ACK,
    output logic        SW_ERR,
    output logic [31:0] SW_RDATA,
    input  logic        CP0_DM,
    input  logic [31:0] EJDM_DATA,
    output logic [5:0]  EJDI_ADDR,
    output logic        EJDI_RW,
    output logic        EJDI_SELDBRS,
    output logic        EJDI_SELDBS,
    output logic [31:0] EJDI_DATA,
    output logic        EJ_STROBE
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_DONE} state_t;

    localparam logic [4:0] NDBRK_L = 5'(NDBRK);

    state_t      state_q;
    logic        last_sw_q;
    logic        owner_sw_q;
    logic        oor_q;
    logic        prb_ack_q, prb_err_q, sw_ack_q, sw_err_q;
    logic [31:0] prb_rdata_q, sw_rdata_q;
    logic [5:0]  ejdi_addr_q;
    logic        ejdi_rw_q, ejdi_seldbrs_q, ejdi_seldbs_q, ej_strobe_q;
    logic [31:0] ejdi_data_q;

    logic        sw_elig;
    logic        gnt_prb_d, gnt_sw_d, rej_sw_d;
    logic        req_rw_d, req_sel_d, oor_d;
    logic [5:0]  req_addr_d;
    logic [31:0] req_wdata_d, rdata_d;

    // Round-robin on ties: the side that did not win last time goes first.
    assign sw_elig   = SW_REQ & CP0_DM;
    assign gnt_prb_d = PRB_REQ & (~sw_elig | last_sw_q);
    assign gnt_sw_d  = sw_elig & (~PRB_REQ | ~last_sw_q);
    assign rej_sw_d  = SW_REQ & ~CP0_DM & ~PRB_REQ;

    assign req_rw_d    = gnt_sw_d ? SW_RW    : PRB_RW;
    assign req_sel_d   = gnt_sw_d ? SW_SEL   : PRB_SEL;
    assign req_addr_d  = gnt_sw_d ? SW_ADDR  : PRB_ADDR;
    assign req_wdata_d = gnt_sw_d ? SW_WDATA : PRB_WDATA;
    assign oor_d       = ~req_sel_d & ({1'b0, req_addr_d[5:2]} >= NDBRK_L);

    assign rdata_d = (ejdi_rw_q && !oor_q) ? EJDM_DATA : 32'h0;

    always_ff @(posedge CORE_CLOCK or negedge RESET_D1_R_N) begin
        if (!RESET_D1_R_N) begin
            state_q        <= ST_IDLE;
            last_sw_q      <= 1'b1;
            owner_sw_q     <= 1'b0;
            oor_q          <= 1'b0;
            prb_ack_q      <= 1'b0;
            prb_err_q      <= 1'b0;
            prb_rdata_q    <= 32'h0;
            sw_ack_q       <= 1'b0;
            sw_err_q       <= 1'b0;
            sw_rdata_q     <= 32'h0;
            ejdi_addr_q    <= 6'h0;
            ejdi_rw_q      <= 1'b0;
            ejdi_seldbrs_q <= 1'b0;
            ejdi_seldbs_q  <= 1'b0;
            ejdi_data_q    <= 32'h0;
            ej_strobe_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_prb_d || gnt_sw_d) begin
                        ejdi_addr_q    <= req_addr_d;
                        ejdi_rw_q      <= req_rw_d;
                        ejdi_data_q    <= req_wdata_d;
                        ejdi_seldbrs_q <= ~req_sel_d;
                        ejdi_seldbs_q  <= req_sel_d;
                        owner_sw_q     <= gnt_sw_d;
                        last_sw_q      <= gnt_sw_d;
                        oor_q          <= oor_d;
                        state_q        <= ST_SETUP;
                    end else if (rej_sw_d) begin
                        // Software outside debug mode never touches the bus.
                        sw_ack_q   <= 1'b1;
                        sw_err_q   <= 1'b1;
                        sw_rdata_q <= 32'h0;
                        state_q    <= ST_DONE;
                    end
                end
                ST_SETUP: begin
                    ej_strobe_q <= ~ejdi_rw_q & ~oor_q;
                    state_q     <= ST_STROBE;
                end
                ST_STROBE: begin
                    ej_strobe_q <= 1'b0;
                    if (owner_sw_q) begin
                        sw_ack_q   <= 1'b1;
                        sw_err_q   <= oor_q;
                        sw_rdata_q <= rdata_d;
                    end else begin
                        prb_ack_q   <= 1'b1;
                        prb_err_q   <= oor_q;
                        prb_rdata_q <= rdata_d;
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    prb_ack_q      <= 1'b0;
                    prb_err_q      <= 1'b0;
                    sw_ack_q       <= 1'b0;
                    sw_err_q       <= 1'b0;
                    ejdi_seldbrs_q <= 1'b0;
                    ejdi_seldbs_q  <= 1'b0;
                    ej_strobe_q    <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign PRB_ACK      = prb_ack_q;
    assign PRB_ERR      = prb_err_q;
    assign PRB_RDATA    = prb_rdata_q;
    assign SW_ACK       = sw_ack_q;
    assign SW_ERR       = sw_err_q;
    assign SW_RDATA     = sw_rdata_q;
    assign EJDI_ADDR    = ejdi_addr_q;
    assign EJDI_RW      = ejdi_rw_q;
    assign EJDI_SELDBRS = ejdi_seldbrs_q;
    assign EJDI_SELDBS  = ejdi_seldbs_q;
    assign EJDI_DATA    = ejdi_data_q;
    assign EJ_STROBE    = ej_strobe_q;

endmodule

// File: tb/tb_ejtag_dreg_arb.sv
// Bench for ejtag_dreg_arb: a register-file model of the breakpoint unit plus a transaction-level reference.
module tb_ejtag_dreg_arb;

    localparam int NDBRK = 2;

    logic        CORE_CLOCK, RESET_D1_R_N;
    logic        PRB_REQ, PRB_RW, PRB_SEL;
    logic [5:0]  PRB_ADDR;
    logic [31:0] PRB_WDATA;
    logic        PRB_ACK, PRB_ERR;
    logic [31:0] PRB_RDATA;
    logic        SW_REQ, SW_RW, SW_SEL;
    logic [5:0]  SW_ADDR;
    logic [31:0] SW_WDATA;
    logic        SW_ACK, SW_ERR;
    logic [31:0] SW_RDATA;
    logic        CP0_DM;
    logic [31:0] EJDM_DATA;
    logic [5:0]  EJDI_ADDR;
    logic        EJDI_RW, EJDI_SELDBRS, EJDI_SELDBS, EJ_STROBE;
    logic [31:0] EJDI_DATA;

    ejtag_dreg_arb #(.NDBRK(NDBRK)) dut (
        .CORE_CLOCK(CORE_CLOCK), .RESET_D1_R_N(RESET_D1_R_N),
        .PRB_REQ(PRB_REQ), .PRB_RW(PRB_RW), .PRB_SEL(PRB_SEL), .PRB_ADDR(PRB_ADDR),
        .PRB_WDATA(PRB_WDATA), .PRB_ACK(PRB_ACK), .PRB_ERR(PRB_ERR), .PRB_RDATA(PRB_RDATA),
        .SW_REQ(SW_REQ), .SW_RW(SW_RW), .SW_SEL(SW_SEL), .SW_ADDR(SW_ADDR),
        .SW_WDATA(SW_WDATA), .SW_ACK(SW_ACK), .SW_ERR(SW_ERR), .SW_RDATA(SW_RDATA),
        .CP0_DM(CP0_DM), .EJDM_DATA(EJDM_DATA), .EJDI_ADDR(EJDI_ADDR), .EJDI_RW(EJDI_RW),
        .EJDI_SELDBRS(EJDI_SELDBRS), .EJDI_SELDBS(EJDI_SELDBS), .EJDI_DATA(EJDI_DATA),
        .EJ_STROBE(EJ_STROBE)
    );

    initial CORE_CLOCK = 1'b0;
    always #5 CORE_CLOCK = ~CORE_CLOCK;

    // Breakpoint unit stand-in: index {SEL, ADDR}
    logic [31:0] dev_mem [0:127];
    logic        dev_init;
    always @(posedge CORE_CLOCK) begin
        if (dev_init) begin
            for (int i = 0; i < 128; i++) dev_mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (EJ_STROBE) begin
            dev_mem[{EJDI_SELDBS, EJDI_ADDR}] <= EJDI_DATA;
        end
    end
    assign EJDM_DATA = dev_mem[{EJDI_SELDBS, EJDI_ADDR}];

    // Reference state
    logic [31:0] ref_mem [0:127];
    bit          m_last_sw;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [109:0] all_outs();
        return {PRB_ACK, PRB_ERR, PRB_RDATA, SW_ACK, SW_ERR, SW_RDATA,
                EJDI_ADDR, EJDI_RW, EJDI_SELDBRS, EJDI_SELDBS, EJDI_DATA, EJ_STROBE};
    endfunction

    function automatic logic [5:0] rand_addr(input bit sel);
        logic [3:0] hi;
        logic [1:0] lo;
        hi = 4'($urandom_range(0, NDBRK - 1));
        lo = 2'($urandom);
        return sel ? 6'($urandom) : {hi, lo};
    endfunction

    task automatic drive(input bit side, input bit rw, input bit sel,
                         input logic [5:0] addr, input logic [31:0] wdata);
        if (side) begin
            SW_RW = rw; SW_SEL = sel; SW_ADDR = addr; SW_WDATA = wdata; SW_REQ = 1'b1;
        end else begin
            PRB_RW = rw; PRB_SEL = sel; PRB_ADDR = addr; PRB_WDATA = wdata; PRB_REQ = 1'b1;
        end
    endtask

    task automatic drop(input bit side);
        if (side) SW_REQ = 1'b0;
        else      PRB_REQ = 1'b0;
    endtask

    // Single-requester access; called at a negedge with the DUT idle.
    task automatic run_access(input bit side, input bit rw, input bit sel,
                              input logic [5:0] addr, input logic [31:0] wdata, input string name);
        bit          rej, oor, exp_err, exp_stb, got_err, bus_bad, other_ack;
        logic [31:0] exp_rd, got_rd, other_before, other_after;
        int          exp_lat, ack_cyc, stb_cnt, stb_cyc;
        rej          = side && !CP0_DM;
        oor          = !sel && (int'(addr[5:2]) >= NDBRK);
        exp_err      = rej || oor;
        exp_stb      = !exp_err && !rw;
        exp_rd       = (!exp_err && rw) ? ref_mem[{sel, addr}] : 32'h0;
        exp_lat      = rej ? 1 : 3;
        other_before = side ? PRB_RDATA : SW_RDATA;
        ack_cyc = 0; stb_cnt = 0; stb_cyc = 0; bus_bad = 0; other_ack = 0;
        got_err = 0; got_rd = 32'h0;
        drive(side, rw, sel, addr, wdata);
        for (int k = 1; k <= 8 && ack_cyc == 0; k++) begin
            @(negedge CORE_CLOCK);
            if (EJ_STROBE) begin stb_cnt++; stb_cyc = k; end
            if (side ? PRB_ACK : SW_ACK) other_ack = 1;
            if (!rej && k <= 3) begin
                if (EJDI_SELDBRS !== !sel || EJDI_SELDBS !== sel || EJDI_RW !== rw ||
                    EJDI_ADDR !== addr || EJDI_DATA !== wdata) bus_bad = 1;
            end else if (EJDI_SELDBRS !== 1'b0 || EJDI_SELDBS !== 1'b0) begin
                bus_bad = 1;
            end
            if (side ? SW_ACK : PRB_ACK) begin
                ack_cyc = k;
                got_err = side ? SW_ERR : PRB_ERR;
                got_rd  = side ? SW_RDATA : PRB_RDATA;
                drop(side);
            end
        end
        if (ack_cyc == 0) drop(side);
        other_after = side ? PRB_RDATA : SW_RDATA;

        checks++;
        if (ack_cyc != exp_lat) begin
            errors++; $display("FAIL %s ack_cycle: got %0d want %0d", name, ack_cyc, exp_lat);
        end
        checks++;
        if (got_err !== exp_err) begin
            errors++; $display("FAIL %s err: got %0b want %0b", name, got_err, exp_err);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            errors++; $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
        end
        checks++;
        if (stb_cnt != (exp_stb ? 1 : 0) || stb_cyc != (exp_stb ? 2 : 0)) begin
            errors++;
            $display("FAIL %s strobe: got count %0d at cycle %0d want count %0d", name, stb_cnt,
                     stb_cyc, exp_stb ? 1 : 0);
        end
        checks++;
        if (bus_bad) begin
            errors++; $display("FAIL %s bus: got wrong EJDI values want latched request fields", name);
        end
        checks++;
        if (other_ack || other_after !== other_before) begin
            errors++;
            $display("FAIL %s other_side: got ack %0b rdata %h want ack 0 rdata %h", name,
                     other_ack, other_after, other_before);
        end
        @(negedge CORE_CLOCK);
        checks++;
        if ({PRB_ACK, SW_ACK, EJDI_SELDBRS, EJDI_SELDBS, EJ_STROBE} !== 5'b0) begin
            errors++;
            $display("FAIL %s after_done: got %b want 00000", name,
                     {PRB_ACK, SW_ACK, EJDI_SELDBRS, EJDI_SELDBS, EJ_STROBE});
        end
        if (exp_stb) ref_mem[{sel, addr}] = wdata;
        if (!rej) m_last_sw = side;
    endtask

    task automatic test_reset();
        RESET_D1_R_N = 1'b0;
        dev_init = 1'b1;
        PRB_REQ = 0; PRB_RW = 0; PRB_SEL = 0; PRB_ADDR = 0; PRB_WDATA = 0;
        SW_REQ = 0;  SW_RW = 0;  SW_SEL = 0;  SW_ADDR = 0;  SW_WDATA = 0;
        CP0_DM = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        m_last_sw = 1'b1;
        repeat (2) @(negedge CORE_CLOCK);
        dev_init = 1'b0;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        RESET_D1_R_N = 1'b1;
        repeat (2) @(negedge CORE_CLOCK);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL idle_after_reset: got %h want 0", all_outs());
        end
    endtask

    // Both sides request together; the loser is serviced in the next slot.
    task automatic test_arbitration();
        for (int r = 0; r < 6; r++) begin
            bit          dm, win_sw, psel, ssel;
            logic [5:0]  pa, sa;
            logic [31:0] exp_prd, exp_srd;
            int          p_cyc, s_cyc, exp_p, exp_s;
            logic [31:0] p_rd, s_rd;
            bit          s_err;
            dm      = (r < 4) ? 1'b1 : 1'($urandom);
            psel    = 1'($urandom); ssel = 1'($urandom);
            pa      = rand_addr(psel); sa = rand_addr(ssel);
            win_sw  = dm && !m_last_sw;
            exp_p   = win_sw ? 7 : 3;
            exp_s   = !dm ? 5 : (win_sw ? 3 : 7);
            exp_prd = ref_mem[{psel, pa}];
            exp_srd = dm ? ref_mem[{ssel, sa}] : 32'h0;
            CP0_DM  = dm;
            drive(1'b0, 1'b1, psel, pa, 32'h0);
            drive(1'b1, 1'b1, ssel, sa, 32'h0);
            p_cyc = 0; s_cyc = 0; p_rd = 0; s_rd = 0; s_err = 0;
            for (int k = 1; k <= 12 && (p_cyc == 0 || s_cyc == 0); k++) begin
                @(negedge CORE_CLOCK);
                if (PRB_ACK && p_cyc == 0) begin p_cyc = k; p_rd = PRB_RDATA; drop(1'b0); end
                if (SW_ACK && s_cyc == 0) begin
                    s_cyc = k; s_rd = SW_RDATA; s_err = SW_ERR; drop(1'b1);
                end
            end
            drop(1'b0); drop(1'b1);
            checks++;
            if (p_cyc != exp_p || s_cyc != exp_s) begin
                errors++;
                $display("FAIL arb_order round %0d: got prb %0d sw %0d want prb %0d sw %0d", r,
                         p_cyc, s_cyc, exp_p, exp_s);
            end
            checks++;
            if (p_rd !== exp_prd || s_rd !== exp_srd || s_err !== !dm) begin
                errors++;
                $display("FAIL arb_data round %0d: got %h %h err %0b want %h %h err %0b", r,
                         p_rd, s_rd, s_err, exp_prd, exp_srd, !dm);
            end
            m_last_sw = dm ? !win_sw : 1'b0;
            @(negedge CORE_CLOCK);
        end
    endtask

    task automatic test_directed();
        CP0_DM = 1'b1;
        run_access(1'b0, 1'b0, 1'b0, 6'h00, 32'h8000_1000, "prb_wr_a0");
        run_access(1'b0, 1'b0, 1'b0, 6'h01, 32'h0000_00F5, "prb_wr_a1");
        run_access(1'b0, 1'b1, 1'b0, 6'h01, 32'h0,         "prb_rd_a1");
        run_access(1'b0, 1'b1, 1'b0, 6'h00, 32'h0,         "prb_rd_a0");
        run_access(1'b1, 1'b0, 1'b1, 6'h3F, 32'h1357_9BDF, "sw_wr_dbs");
        run_access(1'b1, 1'b1, 1'b1, 6'h3F, 32'h0,         "sw_rd_dbs");
    endtask

    task automatic test_reject();
        CP0_DM = 1'b0;
        run_access(1'b1, 1'b1, 1'b0, 6'h01, 32'h0,         "sw_rej_rd");
        run_access(1'b1, 1'b0, 1'b1, 6'h05, 32'hFFFF_FFFF, "sw_rej_wr");
        CP0_DM = 1'b1;
        run_access(1'b1, 1'b1, 1'b1, 6'h05, 32'h0,         "sw_rd_after_rej");
    endtask

    task automatic test_range();
        CP0_DM = 1'b1;
        run_access(1'b0, 1'b0, 1'b0, {4'h3, 2'b00}, 32'hDEAD_BEEF, "prb_oor_wr");
        run_access(1'b0, 1'b1, 1'b0, 6'h00,         32'h0,         "prb_rd_after_oor");
        run_access(1'b1, 1'b1, 1'b0, {4'hF, 2'b11}, 32'h0,         "sw_oor_rd");
        run_access(1'b0, 1'b1, 1'b0, {4'h1, 2'b11}, 32'h0,         "prb_rd_last_inrange");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit         side, rw, sel;
            logic [5:0] addr;
            logic [3:0] hi;
            logic [1:0] lo;
            side   = 1'($urandom);
            rw     = 1'($urandom);
            sel    = 1'($urandom);
            hi     = 4'($urandom_range(0, 3));
            lo     = 2'($urandom);
            addr   = sel ? 6'($urandom) : {hi, lo};
            CP0_DM = ($urandom_range(0, 3) != 0);
            run_access(side, rw, sel, addr, $urandom, "random");
            if ($urandom_range(0, 3) == 0) @(negedge CORE_CLOCK);
        end
    endtask

    task automatic test_reset_mid();
        int ack_cyc, stb_cyc;
        bit got_err;
        CP0_DM = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'h02, 32'h1234_5678);
        repeat (2) @(negedge CORE_CLOCK);
        checks++;
        if (EJ_STROBE !== 1'b1) begin
            errors++; $display("FAIL mid_strobe_before: got %0b want 1", EJ_STROBE);
        end
        #2 RESET_D1_R_N = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0", all_outs());
        end
        m_last_sw = 1'b1;
        @(negedge CORE_CLOCK);
        checks++;
        if (PRB_ACK !== 1'b0 || EJ_STROBE !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hold: got ack %0b strobe %0b want 0 0", PRB_ACK, EJ_STROBE);
        end
        RESET_D1_R_N = 1'b1;
        ack_cyc = 0; stb_cyc = 0; got_err = 1'b1;
        for (int k = 1; k <= 8 && ack_cyc == 0; k++) begin
            @(negedge CORE_CLOCK);
            if (EJ_STROBE) stb_cyc = k;
            if (PRB_ACK) begin ack_cyc = k; got_err = PRB_ERR; drop(1'b0); end
        end
        drop(1'b0);
        checks++;
        if (ack_cyc != 3 || stb_cyc != 2 || got_err !== 1'b0) begin
            errors++;
            $display("FAIL reissue_after_reset: got ack %0d strobe %0d err %0b want 3 2 0",
                     ack_cyc, stb_cyc, got_err);
        end
        ref_mem[{1'b0, 6'h02}] = 32'h1234_5678;
        m_last_sw = 1'b0;
        @(negedge CORE_CLOCK);
        run_access(1'b0, 1'b1, 1'b0, 6'h02, 32'h0, "rd_after_reissue");
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_directed();
        test_reject();
        test_range();
        test_random();
        test_reset_mid();
        test_arbitration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
